// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between the decode FSM (master) and the
// ALU op sequencer (slave).
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_wb;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_wb, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_wb, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one 6502 ALU-class operation per request to an external combinational
// ALU, owns the N/V/Z/C status bits and returns the result over valid/ready.
module alu_op_sequencer #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_op_sequencer_if.slave         cmd_if,
  input  logic                      flag_ld,
  input  logic [3:0]                flag_in,
  output logic [3:0]                flags,
  output logic [7:0]                alu_a,
  output logic [7:0]                alu_b,
  output logic [7:0]                alu_opcode,
  output logic                      alu_carry_in,
  input  logic [7:0]                alu_y,
  input  logic                      alu_carry_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ORA  = 4'h1;
  localparam logic [3:0] OP_EOR  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_SBC  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_ASL  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_BIT  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [7:0] alu_opcode_q, alu_opcode_d;
  logic       alu_cin_q, alu_cin_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_wb_q, res_wb_d;
  logic       res_err_q, res_err_d;
  logic [3:0] flags_q, flags_d;

  logic       carry_src_s;
  logic       y_zero_s;
  logic       v_add_s;
  logic       v_sub_s;

  function automatic logic [7:0] map_opcode(input logic [3:0] op);
    logic [7:0] opc;
    case (op)
      OP_AND:  opc = 8'h01;
      OP_ORA:  opc = 8'h02;
      OP_EOR:  opc = 8'h03;
      OP_ADC:  opc = 8'h21;
      OP_SBC:  opc = 8'h23;
      OP_CMP:  opc = 8'h23;
      OP_ASL:  opc = 8'h11;
      OP_LSR:  opc = 8'h14;
      OP_ROL:  opc = 8'h12;
      OP_ROR:  opc = 8'h14;
      OP_INC:  opc = 8'h22;
      OP_DEC:  opc = 8'h24;
      OP_BIT:  opc = 8'h01;
      OP_PASS: opc = 8'h00;
      default: opc = 8'h00;
    endcase
    return opc;
  endfunction

  // LSR shares the rotate-right ALU opcode, so its carry-in must be forced to 0.
  function automatic logic map_carry_in(input logic [3:0] op, input logic c);
    logic cin;
    case (op)
      OP_ADC, OP_SBC, OP_ROL, OP_ROR: cin = c;
      OP_CMP:                         cin = 1'b1;
      default:                        cin = 1'b0;
    endcase
    return cin;
  endfunction

  assign carry_src_s = flag_ld ? flag_in[0] : flags_q[0];
  assign y_zero_s    = (alu_y == 8'h00);
  assign v_add_s     = (alu_a_q[7] == alu_b_q[7]) & (alu_y[7] != alu_a_q[7]);
  assign v_sub_s     = (alu_a_q[7] != alu_b_q[7]) & (alu_y[7] != alu_a_q[7]);

  // Next-state, ALU operand and result/flag update logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    alu_cin_d    = alu_cin_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_wb_d     = res_wb_q;
    res_err_d    = res_err_q;
    flags_d      = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (flag_ld) begin
          flags_d = flag_in;
        end else begin
          flags_d = flags_q;
        end
        if (cmd_if.cmd_valid) begin
          state_d      = ST_EXEC;
          op_d         = cmd_if.cmd_op;
          alu_a_d      = cmd_if.cmd_a;
          alu_b_d      = cmd_if.cmd_b;
          alu_opcode_d = map_opcode(cmd_if.cmd_op);
          alu_cin_d    = map_carry_in(cmd_if.cmd_op, carry_src_s);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        state_d      = ST_RESP;
        alu_opcode_d = 8'h00;
        alu_cin_d    = 1'b0;
        res_valid_d  = 1'b1;
        res_data_d   = alu_a_q;
        res_wb_d     = 1'b0;
        res_err_d    = 1'b0;
        case (op_q)
          OP_ADC: begin
            res_data_d = alu_y;
            res_wb_d   = 1'b1;
            flags_d    = {alu_y[7], v_add_s, y_zero_s, alu_carry_out};
          end
          OP_SBC: begin
            res_data_d = alu_y;
            res_wb_d   = 1'b1;
            flags_d    = {alu_y[7], v_sub_s, y_zero_s, alu_carry_out};
          end
          OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
            res_data_d = alu_y;
            res_wb_d   = 1'b1;
            flags_d    = {alu_y[7], flags_q[2], y_zero_s, alu_carry_out};
          end
          OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC, OP_PASS: begin
            res_data_d = alu_y;
            res_wb_d   = 1'b1;
            flags_d    = {alu_y[7], flags_q[2], y_zero_s, flags_q[0]};
          end
          OP_CMP: begin
            flags_d = {alu_y[7], flags_q[2], y_zero_s, alu_carry_out};
          end
          OP_BIT: begin
            flags_d = {alu_b_q[7], alu_b_q[6], ((alu_a_q & alu_b_q) == 8'h00), flags_q[0]};
          end
          default: begin
            res_err_d = 1'b1;
            flags_d   = flags_q;
          end
        endcase
      end

      ST_RESP: begin
        if (cmd_if.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        alu_opcode_d = 8'h00;
        res_valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'h0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_opcode_q <= 8'h00;
      alu_cin_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'h00;
      res_wb_q     <= 1'b0;
      res_err_q    <= 1'b0;
      flags_q      <= FLAG_RST;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cin_q    <= alu_cin_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_wb_q     <= res_wb_d;
      res_err_q    <= res_err_d;
      flags_q      <= flags_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign cmd_if.res_valid = res_valid_q;
  assign cmd_if.res_data  = res_data_q;
  assign cmd_if.res_wb    = res_wb_q;
  assign cmd_if.res_err   = res_err_q;
  assign flags            = flags_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_opcode       = alu_opcode_q;
  assign alu_carry_in     = alu_cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model; the ALU
// drives a junk carry (1) on opcodes whose carry must not reach the flags.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       flag_ld;
  logic [3:0] flag_in;
  logic [3:0] flags;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_opcode;
  logic       alu_carry_in;
  logic [7:0] alu_y;
  logic       alu_carry_out;
  logic [8:0] sum9;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.FLAG_RST(4'b0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (bus),
    .flag_ld       (flag_ld),
    .flag_in       (flag_in),
    .flags         (flags),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_carry_in  (alu_carry_in),
    .alu_y         (alu_y),
    .alu_carry_out (alu_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sum9          = 9'd0;
    alu_y         = 8'h00;
    alu_carry_out = 1'b1;
    case (alu_opcode)
      8'h00: alu_y = alu_a;
      8'h01: alu_y = alu_a & alu_b;
      8'h02: alu_y = alu_a | alu_b;
      8'h03: alu_y = alu_a ^ alu_b;
      8'h21: begin
        sum9          = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
        alu_y         = sum9[7:0];
        alu_carry_out = sum9[8];
      end
      8'h23: begin
        sum9          = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_carry_in};
        alu_y         = sum9[7:0];
        alu_carry_out = sum9[8];
      end
      8'h11: begin
        alu_y         = {alu_a[6:0], 1'b0};
        alu_carry_out = alu_a[7];
      end
      8'h12: begin
        alu_y         = {alu_a[6:0], alu_carry_in};
        alu_carry_out = alu_a[7];
      end
      8'h14: begin
        alu_y         = {alu_carry_in, alu_a[7:1]};
        alu_carry_out = alu_a[0];
      end
      8'h22: alu_y = alu_a + 8'd1;
      8'h24: alu_y = alu_a - 8'd1;
      default: alu_y = 8'h00;
    endcase
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] pre;
    logic [7:0] opc;
    logic       cin;
    logic [7:0] data;
    logic       wb;
    logic       err;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    flag_ld = 1'b1;
    flag_in = v.pre;
    @(negedge clk);
    flag_ld       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    chk($sformatf("v%0d_ready", i), {31'd0, bus.cmd_ready}, 32'd1);
    chk($sformatf("v%0d_preflags", i), {28'd0, flags}, {28'd0, v.pre});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk($sformatf("v%0d_opcode", i), {24'd0, alu_opcode}, {24'd0, v.opc});
    chk($sformatf("v%0d_cin", i), {31'd0, alu_carry_in}, {31'd0, v.cin});
    chk($sformatf("v%0d_alu_a", i), {24'd0, alu_a}, {24'd0, v.a});
    chk($sformatf("v%0d_early_valid", i), {31'd0, bus.res_valid}, 32'd0);
    chk($sformatf("v%0d_busy", i), {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_valid", i), {31'd0, bus.res_valid}, 32'd1);
    chk($sformatf("v%0d_data", i), {24'd0, bus.res_data}, {24'd0, v.data});
    chk($sformatf("v%0d_wb", i), {31'd0, bus.res_wb}, {31'd0, v.wb});
    chk($sformatf("v%0d_err", i), {31'd0, bus.res_err}, {31'd0, v.err});
    chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, v.flg});
    chk($sformatf("v%0d_opc_idle", i), {24'd0, alu_opcode}, 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk($sformatf("v%0d_drop", i), {31'd0, bus.res_valid}, 32'd0);
    chk($sformatf("v%0d_back_idle", i), {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    //            op     a      b      pre      opc    cin   data   wb    err   flags
    vecs[0]  = '{4'h0, 8'hF0, 8'h3C, 4'b0100, 8'h01, 1'b0, 8'h30, 1'b1, 1'b0, 4'b0100};
    vecs[1]  = '{4'h1, 8'h00, 8'h00, 4'b0000, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0010};
    vecs[2]  = '{4'h2, 8'hFF, 8'h0F, 4'b0001, 8'h03, 1'b0, 8'hF0, 1'b1, 1'b0, 4'b1001};
    vecs[3]  = '{4'h3, 8'h50, 8'h50, 4'b0000, 8'h21, 1'b0, 8'hA0, 1'b1, 1'b0, 4'b1100};
    vecs[4]  = '{4'h4, 8'h00, 8'h01, 4'b0101, 8'h23, 1'b1, 8'hFF, 1'b1, 1'b0, 4'b1000};
    vecs[5]  = '{4'h5, 8'h40, 8'h40, 4'b0100, 8'h23, 1'b1, 8'h40, 1'b0, 1'b0, 4'b0111};
    vecs[6]  = '{4'h7, 8'h01, 8'h55, 4'b0000, 8'h14, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0011};
    vecs[7]  = '{4'h8, 8'h80, 8'h00, 4'b0001, 8'h12, 1'b1, 8'h01, 1'b1, 1'b0, 4'b0001};
    vecs[8]  = '{4'hB, 8'h00, 8'h00, 4'b0000, 8'h24, 1'b0, 8'hFF, 1'b1, 1'b0, 4'b1000};
    vecs[9]  = '{4'hC, 8'h0F, 8'hC0, 4'b0000, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 4'b1110};
    vecs[10] = '{4'hE, 8'h12, 8'h34, 4'b1011, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1, 4'b1011};
    vecs[11] = '{4'h6, 8'h81, 8'h00, 4'b0000, 8'h11, 1'b0, 8'h02, 1'b1, 1'b0, 4'b0001};
    vecs[12] = '{4'h9, 8'h01, 8'h00, 4'b0001, 8'h14, 1'b1, 8'h80, 1'b1, 1'b0, 4'b1001};
    vecs[13] = '{4'hA, 8'hFF, 8'h00, 4'b0001, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0011};
    vecs[14] = '{4'hD, 8'h7F, 8'h00, 4'b1110, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0, 4'b0100};
    vecs[15] = '{4'h3, 8'h80, 8'hFF, 4'b0000, 8'h21, 1'b0, 8'h7F, 1'b1, 1'b0, 4'b0101};
    vecs[16] = '{4'hF, 8'hAB, 8'hCD, 4'b0110, 8'h00, 1'b0, 8'hAB, 1'b0, 1'b1, 4'b0110};

    rst           = 1'b1;
    flag_ld       = 1'b0;
    flag_in       = 4'b0000;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.res_data}, 32'd0);
    chk("rst_wb_err", {30'd0, bus.res_wb, bus.res_err}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("rst_alu_opc", {23'd0, alu_opcode, alu_carry_in}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], i);
    end

    // flag_ld coinciding with accept: carry-in comes from flag_in.
    @(negedge clk);
    flag_ld       = 1'b1;
    flag_in       = 4'b0001;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h3;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    @(negedge clk);
    flag_ld       = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("ldacc_cin", {31'd0, alu_carry_in}, 32'd1);
    chk("ldacc_flags_loaded", {28'd0, flags}, 32'd1);
    @(negedge clk);
    chk("ldacc_data", {24'd0, bus.res_data}, 32'h01);
    chk("ldacc_flags", {28'd0, flags}, 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Backpressure: result held, new commands and flag loads ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h1;
    bus.cmd_a     = 8'h5A;
    bus.cmd_b     = 8'hA5;
    @(negedge clk);
    bus.cmd_op = 4'h2;
    bus.cmd_a  = 8'h33;
    flag_ld    = 1'b1;
    flag_in    = 4'b0111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {31'd0, bus.res_valid}, 32'd1);
      chk($sformatf("bp%0d_data", k), {24'd0, bus.res_data}, 32'hFF);
      chk($sformatf("bp%0d_wb_err", k), {30'd0, bus.res_wb, bus.res_err}, 32'd2);
      chk($sformatf("bp%0d_ready", k), {31'd0, bus.cmd_ready}, 32'd0);
      chk($sformatf("bp%0d_flags", k), {28'd0, flags}, 32'b1000);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    flag_ld       = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("bp_release", {31'd0, bus.res_valid}, 32'd0);
    chk("bp_flags_kept", {28'd0, flags}, 32'b1000);

    // Reset during EXEC aborts the op and restores reset flags.
    flag_ld = 1'b1;
    flag_in = 4'b1111;
    @(negedge clk);
    flag_ld       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h3;
    bus.cmd_a     = 8'h01;
    bus.cmd_b     = 8'h01;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rstx_in_exec", {24'd0, alu_opcode}, 32'h21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstx_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rstx_flags", {28'd0, flags}, 32'd0);
    chk("rstx_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rstx_opc", {24'd0, alu_opcode}, 32'd0);
    @(negedge clk);
    chk("rstx_no_result", {31'd0, bus.res_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
